memory_stage: RTL

Memory (M) stage of the five-stage MIPS pipeline: sits directly downstream of the execute stage and upstream of writeback. It registers the execute-stage outputs and runs a request/acknowledge handshake with the data memory for loads and stores. While an access is outstanding it asserts a busy signal to the hazard unit. It presents `ALUOutM` for E-stage forwarding and the load/ALU data to writeback.

---
 rtl/memory_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory stage of the five-stage MIPS pipeline: pipeline register plus a
// req/ack data-memory handshake. Define MEMSTAGE_TIMEOUT_EN to add the ack watchdog and MemErrM.
module memory_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jumpE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic [3:0]  MemtoRegE,
    input  logic [4:0]  WriteRegE,
    input  logic [31:0] ALUMultOutE,
    input  logic [31:0] WriteDataE,
    input  logic [31:0] PCPlus4E,
    input  logic        StallM,
    input  logic        FlushM,
    output logic        MemBusyM,
    output logic        jumpM,
    output logic        RegWriteM,
    output logic [3:0]  MemtoRegM,
    output logic [4:0]  WriteRegM,
    output logic [31:0] ALUOutM,
    output logic [31:0] PCPlus4M,
    output logic [31:0] ReadDataM,
    output logic        DataReq,
    output logic        DataWE,
    output logic [31:0] DataAdr,
    output logic [31:0] DataWr,
`ifdef MEMSTAGE_TIMEOUT_EN
    output logic        MemErrM,
`endif
    input  logic        DataAck,
    input  logic [31:0] DataRd
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

    localparam logic [3:0] MEMTOREG_BUBBLE = 4'b1110;

    stateT       state, stateNext;
    logic        MemWriteM;
    logic [31:0] WriteDataM;
    logic [31:0] holdData;
    logic        memOpE;
    logic        prFlush;
    logic        prAdvance;
    logic        timeoutHit;

    assign memOpE    = MemWriteE | MemtoRegE[0];
    assign MemBusyM  = (state == ACCESS) & ~DataAck;
    assign prFlush   = ~MemBusyM & FlushM;
    assign prAdvance = ~MemBusyM & ~FlushM & ~StallM;

    assign DataReq = (state == ACCESS);
    assign DataWE  = MemWriteM;
    assign DataAdr = ALUOutM;
    assign DataWr  = WriteDataM;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            jumpM      <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= MEMTOREG_BUBBLE;
            WriteRegM  <= '0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (prFlush) begin
            jumpM      <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= MEMTOREG_BUBBLE;
            WriteRegM  <= '0;
            ALUOutM    <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (prAdvance) begin
            jumpM      <= jumpE;
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            MemtoRegM  <= MemtoRegE;
            WriteRegM  <= WriteRegE;
            ALUOutM    <= ALUMultOutE;
            WriteDataM <= WriteDataE;
            PCPlus4M   <= PCPlus4E;
        end
    end

`ifdef MEMSTAGE_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] waitCnt;

    // Fires in the TIMEOUT_CYCLES-th unacknowledged ACCESS cycle.
    assign timeoutHit = (state == ACCESS) & ~DataAck &
                        (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            waitCnt <= '0;
        end else if (prAdvance & memOpE) begin
            waitCnt <= '0;
        end else if (state == ACCESS) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MemErrM <= 1'b0;
        end else if (timeoutHit) begin
            MemErrM <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        stateNext = state;
        if (MemBusyM) begin
            if (timeoutHit) begin
                stateNext = DONE;
            end
        end else if (FlushM) begin
            stateNext = IDLE;
        end else if (StallM) begin
            // Not busy in ACCESS means this cycle carries the ack.
            if (state == ACCESS) begin
                stateNext = DONE;
            end
        end else begin
            stateNext = memOpE ? ACCESS : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holdData <= '0;
        end else if ((state == ACCESS) && DataAck) begin
            holdData <= DataRd;
        end else if (timeoutHit) begin
            holdData <= 32'hDEAD_BEEF;
        end
    end

    always_comb begin
        ReadDataM = '0;
        if (!MemWriteM) begin
            if ((state == ACCESS) && DataAck) begin
                ReadDataM = DataRd;
            end else if (state == DONE) begin
                ReadDataM = holdData;
            end
        end
    end

endmodule
